// File: rtl/nibble_alu_pkg.sv
// Shared types for the pipelined nibble ALU: mode encoding and the S1 beat.
package nibble_alu_pkg;

  // Widest operand supported; S1 beats are stored at this width.
  localparam int unsigned MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } alu_mode_e;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    alu_mode_e            mode;
  } s1_beat_t;

endpackage

// File: rtl/nibble_alu_core.sv
// Combinational ALU datapath: add, subtract, accumulate, load, optional clamp.
module nibble_alu_core
  import nibble_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SAT_EN = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  alu_mode_e        mode,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             sat
);

  logic [WIDTH:0] w_sum;

  // Raw arithmetic at WIDTH+1 bits; the top bit is carry (ADD/ACC) or borrow (SUB).
  always_comb begin
    w_sum = '0;
    case (mode)
      MODE_ADD:  w_sum = {1'b0, a} + {1'b0, b};
      MODE_SUB:  w_sum = {1'b0, a} - {1'b0, b};
      MODE_ACC:  w_sum = {1'b0, acc} + {1'b0, a};
      MODE_LOAD: w_sum = {1'b0, b};
      default:   w_sum = '0;
    endcase
  end

  // Clamp on overflow when saturation is enabled; carry always reports the raw flag.
  always_comb begin
    r     = w_sum[WIDTH-1:0];
    carry = w_sum[WIDTH];
    sat   = 1'b0;
    if (SAT_EN != 0 && w_sum[WIDTH]) begin
      sat = 1'b1;
      r   = (mode == MODE_SUB) ? '0 : '1;
    end
  end

endmodule

// File: rtl/nibble_alu_pipe.sv
// Two-stage valid/ready ALU pipeline with accumulator and consumed-result counter.
module nibble_alu_pipe
  import nibble_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SAT_EN = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             sat,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] txn_count
);

  s1_beat_t         r_s1;
  logic             r_s1_valid;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_sat;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_txn;

  logic             w_s2_adv;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_s2_load;
  logic             w_consume;
  logic [WIDTH-1:0] w_core_r;
  logic             w_core_carry;
  logic             w_core_sat;
  logic             w_unused_hi;

  assign w_s2_adv   = !r_out_valid | out_ready;
  assign w_in_ready = !r_s1_valid | w_s2_adv;
  assign w_in_fire  = in_valid & w_in_ready;
  assign w_s2_load  = r_s1_valid & w_s2_adv;
  assign w_consume  = r_out_valid & out_ready;

  // Beats are held at package width; bits above WIDTH are always zero.
  assign w_unused_hi = ^{r_s1.a, r_s1.b};

  nibble_alu_core #(
    .WIDTH (WIDTH),
    .SAT_EN(SAT_EN)
  ) u_core (
    .a    (r_s1.a[WIDTH-1:0]),
    .b    (r_s1.b[WIDTH-1:0]),
    .acc  (r_acc),
    .mode (r_s1.mode),
    .r    (w_core_r),
    .carry(w_core_carry),
    .sat  (w_core_sat)
  );

  // S1: capture operands on handshake; empties when its beat moves into S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1.a     <= MAX_WIDTH'(op_a);
      r_s1.b     <= MAX_WIDTH'(op_b);
      r_s1.mode  <= alu_mode_e'(mode);
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 and accumulator: load on S1->S2 transfer, hold under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_sat       <= 1'b0;
      r_acc       <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_core_r;
      r_carry     <= w_core_carry;
      r_sat       <= w_core_sat;
      if (r_s1.mode == MODE_ACC || r_s1.mode == MODE_LOAD) begin
        r_acc <= w_core_r;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Count consumed results, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txn <= '0;
    end else if (w_consume) begin
      r_txn <= r_txn + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign sat       = r_sat;
  assign acc_value = r_acc;
  assign txn_count = r_txn;

endmodule

// File: doc/nibble_alu_pipe.md
Name: nibble_alu_pipe

Overview:
- Parametrised successor to the registered nibble adder.
- Two-stage pipelined ALU with WIDTH-bit operands, four modes (add, subtract, accumulate, load) and optional saturation.
- Valid/ready handshakes on both sides, so it can sit between ui_in/uo_out glue and future on-chip producers and consumers without dropping data.

Parameters:
- WIDTH, 4, operand/result width in bits (2..16).
- SAT_EN, 0, 1 = clamp ADD/ACC at 2^WIDTH-1 and SUB at 0; 0 = wrap modulo 2^WIDTH.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  result value.
- carry  output  1  carry out (ADD/ACC) or borrow (SUB); 0 for LOAD.
- sat  output  1  result was clamped (always 0 when SAT_EN=0).
- acc_value  output  WIDTH  current accumulator contents.
- txn_count  output  CNT_W  number of results consumed (out_valid & out_ready), wraps.

Behaviour:
- Reset (async, active-high, asserted at any time) forces all of the following to 0:
  - s1_valid, out_valid, result, carry, sat, acc_value, txn_count.
  - Any beats in flight are discarded.
- Stage S1 (input register):
  - Captures op_a, op_b and mode on in_valid & in_ready.
  - in_ready = !s1_valid | s2_adv, where s2_adv = !out_valid | out_ready.
  - in_ready is a combinational function of registered state and out_ready only; there is no path from in_valid.
- Stage S2 (output register):
  - Loads when s1_valid & s2_adv.
  - The compute is combinational between S1 and S2, using acc_value as it stands at that edge.
- Latency and throughput:
  - Latency is 2 cycles from input handshake to out_valid.
  - Full throughput is one beat per cycle while out_ready = 1.
- Modes, with the sum computed at WIDTH+1 bits:
  - ADD: {carry, r} = a + b.
  - SUB: {borrow, r} = a - b, with borrow = (a < b).
  - ACC: {carry, r} = acc + a (op_b ignored); acc updates to the final result.
  - LOAD: r = op_b; acc updates to op_b; carry = 0.
- Accumulator sequencing:
  - acc updates only on the S1->S2 transfer of an ACC or LOAD beat.
  - Back-to-back ACC beats chain correctly with no hazard.
- Saturation (SAT_EN = 1):
  - ADD/ACC with carry: r = all-ones, sat = 1.
  - SUB with borrow: r = 0, sat = 1.
  - carry still reports the raw carry/borrow.
  - The accumulator stores the saturated value.
- Backpressure:
  - While out_valid & !out_ready, the S2 registers are held stable.
  - S1 fills; once S1 is also full, in_ready = 0.
  - No beat is lost or duplicated.
- Simultaneous consume and refill:
  - out_valid & out_ready & s1_valid loads a new S2 beat in the same cycle.
  - out_valid stays 1.
- txn_count increments on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Output stability: result, carry and sat change only when S2 loads or reset asserts.

Decomposition:
- Package nibble_alu_pkg:
  - alu_mode_e enum (ADD, SUB, ACC, LOAD).
  - Typedef for the S1 beat struct (a, b, mode).
- Sub-module nibble_alu_core:
  - Purely combinational.
  - Inputs: a, b, acc, mode. Outputs: r, carry, sat. Parameters: WIDTH, SAT_EN.
  - Verified stand-alone with an exhaustive sweep at WIDTH = 4.
- Top-level nibble_alu_pipe: handshake registers, accumulator and counter.

Test Plan (WIDTH=4 unless stated):
1. Reset mid-stream: stream ADD beats with out_ready=1, assert reset for 1 cycle. out_valid, acc_value and txn_count drop to 0 asynchronously, and the next accepted beat is the first result seen.
2. ADD/SUB, SAT_EN=0, out_ready=1: ADD 9+8 -> result=1, carry=1 two cycles later. SUB 3-5 -> result=14, carry=1. SUB 7-2 -> result=5, carry=0.
3. Saturation, SAT_EN=1: ADD 9+8 -> result=15, sat=1. SUB 3-5 -> result=0, sat=1. ADD 2+3 -> result=5, sat=0.
4. Accumulator chain, back-to-back in consecutive cycles: LOAD b=2, ACC a=5, ACC a=6, ACC a=4. Results 2, 7, 13, 1 (carry=1 on the last). acc_value ends at 1.
5. Backpressure: hold out_ready=0 and offer 3 beats. Only 2 are accepted and in_ready=0 on the third. result is held stable. Releasing out_ready drains the beats in order, txn_count=2, then the third beat is accepted.
6. Counter wrap, CNT_W=2: consume 5 beats -> txn_count=1.
